gpio_ctrl: RTL and testbench

Parametrised GPIO peripheral on the device bus, successor to the basic GPIO block. It adds:
- atomic set/clear of outputs;
- 2-flop input synchronisation;
- optional per-input debouncing;
- per-input rising/falling edge interrupts with sticky write-1-to-clear status and a level interrupt `irq_o` to the core.

---
 rtl/gpio_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_gpio_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gpio_ctrl
// Purpose  : Bus-mapped GPIO peripheral. It provides registered outputs with
//            atomic set/clear, inputs synchronised by two flops, optional
//            per-input debouncing, and per-input rising/falling edge
//            interrupts. The edge flags are sticky, write-1-to-clear status
//            bits, and their OR drives a level interrupt.
// Config   : `GPIO_CTRL_DEBOUNCE_EN -- when defined, each input gets a
//            debounce counter. When undefined, the debounced value is the
//            synchronised value.
// Ports    : clk_i, rst_ni (async, active-low)
//            device_req_i/addr_i/we_i/be_i/wdata_i : single-cycle bus request
//            device_rvalid_o/rdata_o               : response, 1 cycle later
//            gp_i  : asynchronous inputs
//            gp_o  : registered outputs
//            irq_o : registered OR of interrupt status
// Revision : 1.0 - initial release
// ============================================================================
module gpio_ctrl #(
    parameter int GpiWidth  = 8,
    parameter int GpoWidth  = 16,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int RegAddr   = 12,
    parameter int DbncCount = 500
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 device_req_i,
    input  logic [AddrWidth-1:0] device_addr_i,
    input  logic                 device_we_i,
    input  logic [3:0]           device_be_i,
    input  logic [DataWidth-1:0] device_wdata_i,
    output logic                 device_rvalid_o,
    output logic [DataWidth-1:0] device_rdata_o,
    input  logic [GpiWidth-1:0]  gp_i,
    output logic [GpoWidth-1:0]  gp_o,
    output logic                 irq_o
);

    localparam logic [RegAddr-1:0] c_ADDR_OUT    = RegAddr'(12'h000);
    localparam logic [RegAddr-1:0] c_ADDR_IN     = RegAddr'(12'h004);
    localparam logic [RegAddr-1:0] c_ADDR_IN_DB  = RegAddr'(12'h008);
    localparam logic [RegAddr-1:0] c_ADDR_SET    = RegAddr'(12'h00C);
    localparam logic [RegAddr-1:0] c_ADDR_CLR    = RegAddr'(12'h010);
    localparam logic [RegAddr-1:0] c_ADDR_RISE   = RegAddr'(12'h014);
    localparam logic [RegAddr-1:0] c_ADDR_FALL   = RegAddr'(12'h018);
    localparam logic [RegAddr-1:0] c_ADDR_STATUS = RegAddr'(12'h01C);

    logic [GpoWidth-1:0]  r_out;
    logic [GpiWidth-1:0]  r_rise_en;
    logic [GpiWidth-1:0]  r_fall_en;
    logic [GpiWidth-1:0]  r_status;
    logic [GpiWidth-1:0]  r_sync1;
    logic [GpiWidth-1:0]  r_sync2;
    logic [GpiWidth-1:0]  r_dbnc_q;
    logic                 r_irq;
    logic                 r_rvalid;
    logic [DataWidth-1:0] r_rdata;

    logic [RegAddr-1:0]   w_addr;
    logic                 w_wr;
    logic                 w_rd;
    logic [31:0]          w_bemask;
    logic [31:0]          w_wd;
    logic [GpoWidth-1:0]  w_out_nxt;
    logic [GpiWidth-1:0]  w_dbnc;
    logic [GpiWidth-1:0]  w_hw_set;
    logic [GpiWidth-1:0]  w_w1c;
    logic [DataWidth-1:0] w_rd_val;
    logic                 w_unused;

    assign w_addr   = device_addr_i[RegAddr-1:0];
    assign w_wr     = device_req_i & device_we_i;
    assign w_rd     = device_req_i & ~device_we_i;
    assign w_bemask = {{8{device_be_i[3]}}, {8{device_be_i[2]}},
                       {8{device_be_i[1]}}, {8{device_be_i[0]}}};
    // Write data with disabled bytes forced to 0; every write path uses this
    // so a disabled byte can neither set, clear nor overwrite anything.
    assign w_wd     = device_wdata_i & w_bemask;

    // Upper address bits are deliberately not decoded; upper write-data bits
    // beyond the channel widths are dropped.
    assign w_unused = ^{device_addr_i[AddrWidth-1:RegAddr], w_wd, w_bemask};

    // ------------------------------------------------------------------
    // Input synchronisation
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= gp_i;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: the output follows the input only after DbncCount
    // consecutive cycles of disagreement; any agreement restarts the count.
    // ------------------------------------------------------------------
`ifdef GPIO_CTRL_DEBOUNCE_EN
    localparam int c_CNT_W = $clog2(DbncCount);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DbncCount - 1);

    for (genvar gi = 0; gi < GpiWidth; gi++) begin : g_dbnc
        logic [c_CNT_W-1:0] r_cnt;
        logic               r_dbnc;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_cnt  <= '0;
                r_dbnc <= 1'b0;
            end else if (r_sync2[gi] == r_dbnc) begin
                r_cnt  <= '0;
            end else if (r_cnt == c_CNT_MAX) begin
                r_dbnc <= r_sync2[gi];
                r_cnt  <= '0;
            end else begin
                r_cnt  <= r_cnt + c_CNT_W'(1);
            end
        end

        assign w_dbnc[gi] = r_dbnc;
    end
`else
    assign w_dbnc = r_sync2;
`endif

    // ------------------------------------------------------------------
    // Edge detection and interrupt status
    // ------------------------------------------------------------------
    assign w_hw_set = ( w_dbnc & ~r_dbnc_q & r_rise_en) |
                      (~w_dbnc &  r_dbnc_q & r_fall_en);
    assign w_w1c    = (w_wr && (w_addr == c_ADDR_STATUS)) ? w_wd[GpiWidth-1:0]
                                                          : '0;

    // ------------------------------------------------------------------
    // Output register next value (plain write, set, clear)
    // ------------------------------------------------------------------
    always_comb begin
        w_out_nxt = r_out;
        if (w_wr) begin
            case (w_addr)
                c_ADDR_OUT: w_out_nxt = (r_out & ~w_bemask[GpoWidth-1:0]) |
                                        w_wd[GpoWidth-1:0];
                c_ADDR_SET: w_out_nxt = r_out | w_wd[GpoWidth-1:0];
                c_ADDR_CLR: w_out_nxt = r_out & ~w_wd[GpoWidth-1:0];
                default:    w_out_nxt = r_out;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read mux; unlisted and write-only addresses read 0
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_val = '0;
        case (w_addr)
            c_ADDR_OUT:    w_rd_val[GpoWidth-1:0] = r_out;
            c_ADDR_IN:     w_rd_val[GpiWidth-1:0] = r_sync2;
            c_ADDR_IN_DB:  w_rd_val[GpiWidth-1:0] = w_dbnc;
            c_ADDR_RISE:   w_rd_val[GpiWidth-1:0] = r_rise_en;
            c_ADDR_FALL:   w_rd_val[GpiWidth-1:0] = r_fall_en;
            c_ADDR_STATUS: w_rd_val[GpiWidth-1:0] = r_status;
            default:       w_rd_val = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out     <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_status  <= '0;
            r_dbnc_q  <= '0;
            r_irq     <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_out    <= w_out_nxt;
            r_dbnc_q <= w_dbnc;
            // Hardware set is OR-ed after the clear so it wins a collision.
            r_status <= (r_status & ~w_w1c) | w_hw_set;
            r_irq    <= |r_status;
            r_rvalid <= device_req_i;
            r_rdata  <= w_rd ? w_rd_val : '0;
            if (w_wr && (w_addr == c_ADDR_RISE)) begin
                r_rise_en <= (r_rise_en & ~w_bemask[GpiWidth-1:0]) |
                             w_wd[GpiWidth-1:0];
            end
            if (w_wr && (w_addr == c_ADDR_FALL)) begin
                r_fall_en <= (r_fall_en & ~w_bemask[GpiWidth-1:0]) |
                             w_wd[GpiWidth-1:0];
            end
        end
    end

    assign gp_o            = r_out;
    assign irq_o           = r_irq;
    assign device_rvalid_o = r_rvalid;
    assign device_rdata_o  = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_gpio_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_ctrl
// Purpose  : Self-checking bench for gpio_ctrl. A vector table covers the
//            register map, hand sequences cover interrupt timing, W1C/set
//            collision and debounce glitches, and a randomized phase is
//            checked cycle by cycle against a queue-based reference model.
// Config   : honours `GPIO_CTRL_DEBOUNCE_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_ctrl;

    localparam int GPI  = 8;
    localparam int GPO  = 16;
    localparam int DBNC = 4;
`ifdef GPIO_CTRL_DEBOUNCE_EN
    localparam int c_LAT = 2 + DBNC;   // edges from gp_i change to dbnc change
`else
    localparam int c_LAT = 2;
`endif

    logic            clk;
    logic            rst_ni;
    logic            req;
    logic [31:0]     addr;
    logic            we;
    logic [3:0]      be;
    logic [31:0]     wdata;
    logic            rvalid;
    logic [31:0]     rdata;
    logic [GPI-1:0]  gp_i;
    logic [GPO-1:0]  gp_o;
    logic            irq;

    int n_chk  = 0;
    int n_fail = 0;

    gpio_ctrl #(
        .GpiWidth (GPI),
        .GpoWidth (GPO),
        .AddrWidth(32),
        .DataWidth(32),
        .RegAddr  (12),
        .DbncCount(DBNC)
    ) u_dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .device_req_i   (req),
        .device_addr_i  (addr),
        .device_we_i    (we),
        .device_be_i    (be),
        .device_wdata_i (wdata),
        .device_rvalid_o(rvalid),
        .device_rdata_o (rdata),
        .gp_i           (gp_i),
        .gp_o           (gp_o),
        .irq_o          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Reference model: delays held in queues, debounce judged by looking
    // back over the last DBNC synchronised samples.
    // ------------------------------------------------------------------
    logic [GPO-1:0] m_out;
    logic [GPI-1:0] m_ren, m_fen, m_stat, m_dbnc, m_dbncq;
    logic           m_irq, m_rvalid;
    logic [31:0]    m_rdata;
    logic [GPI-1:0] gp_hist[$];   // last two gp_i samples; [0] is the sync value
    logic [GPI-1:0] s_hist[$];    // recent synchronised samples

    task automatic m_reset();
        m_out = '0; m_ren = '0; m_fen = '0; m_stat = '0;
        m_dbnc = '0; m_dbncq = '0; m_irq = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        gp_hist.delete();
        gp_hist.push_back('0);
        gp_hist.push_back('0);
        s_hist.delete();
    endtask

    function automatic logic [GPI-1:0] m_dbnc_now();
`ifdef GPIO_CTRL_DEBOUNCE_EN
        return m_dbnc;
`else
        return gp_hist[0];
`endif
    endfunction

    task automatic m_step();
        logic [GPI-1:0] sp, dp, setb, w1c;
        logic [31:0]    msk, wd, rd;
        logic [11:0]    a;
        sp   = gp_hist[0];
        dp   = m_dbnc_now();
        setb = (dp & ~m_dbncq & m_ren) | (~dp & m_dbncq & m_fen);
        a    = addr[11:0];
        msk  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        wd   = wdata & msk;
        rd   = '0;
        case (a)
            12'h000: rd = {16'h0, m_out};
            12'h004: rd = {24'h0, sp};
            12'h008: rd = {24'h0, dp};
            12'h014: rd = {24'h0, m_ren};
            12'h018: rd = {24'h0, m_fen};
            12'h01C: rd = {24'h0, m_stat};
            default: rd = '0;
        endcase
        m_rvalid = req;
        m_rdata  = (req && !we) ? rd : 32'h0;
        m_irq    = |m_stat;
        m_dbncq  = dp;
`ifdef GPIO_CTRL_DEBOUNCE_EN
        s_hist.push_back(sp);
        if (s_hist.size() > DBNC) void'(s_hist.pop_front());
        if (s_hist.size() == DBNC) begin
            for (int b = 0; b < GPI; b++) begin
                bit stable_other = 1'b1;
                foreach (s_hist[k]) if (s_hist[k][b] == m_dbnc[b]) stable_other = 1'b0;
                if (stable_other) m_dbnc[b] = ~m_dbnc[b];
            end
        end
`endif
        gp_hist.push_back(gp_i);
        void'(gp_hist.pop_front());
        w1c = '0;
        if (req && we) begin
            case (a)
                12'h000: m_out = (m_out & ~msk[GPO-1:0]) | wd[GPO-1:0];
                12'h00C: m_out = m_out | wd[GPO-1:0];
                12'h010: m_out = m_out & ~wd[GPO-1:0];
                12'h014: m_ren = (m_ren & ~msk[GPI-1:0]) | wd[GPI-1:0];
                12'h018: m_fen = (m_fen & ~msk[GPI-1:0]) | wd[GPI-1:0];
                12'h01C: w1c = wd[GPI-1:0];
                default: ;
            endcase
        end
        m_stat = (m_stat & ~w1c) | setb;
    endtask

    always @(posedge clk) begin
        if (!rst_ni) m_reset();
        else         m_step();
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic bus_op(input logic w, input logic [31:0] a, input logic [3:0] b,
                          input logic [31:0] d);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        tick();
        req = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input string nm, input logic [31:0] a, input logic [31:0] exp);
        bus_op(1'b0, a, 4'hF, 32'h0);
        chk({nm, "_rvalid"}, {31'h0, rvalid}, 32'h1);
        chk(nm, rdata, exp);
    endtask

    task automatic check_all(input string nm);
        chk({nm, "_gp_o"},   {16'h0, gp_o},   {16'h0, m_out});
        chk({nm, "_irq"},    {31'h0, irq},    {31'h0, m_irq});
        chk({nm, "_rvalid"}, {31'h0, rvalid}, {31'h0, m_rvalid});
        chk({nm, "_rdata"},  rdata,           m_rdata);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [15:0] exp_gpo;
    } vec_t;

    vec_t tbl[24];

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        tbl[0]  = '{1'b0, 32'h00, 4'hF, 32'h0, 32'h0, 16'h0};
        tbl[1]  = '{1'b0, 32'h04, 4'hF, 32'h0, 32'h0, 16'h0};
        tbl[2]  = '{1'b0, 32'h08, 4'hF, 32'h0, 32'h0, 16'h0};
        tbl[3]  = '{1'b0, 32'h0C, 4'hF, 32'h0, 32'h0, 16'h0};
        tbl[4]  = '{1'b0, 32'h10, 4'hF, 32'h0, 32'h0, 16'h0};
        tbl[5]  = '{1'b0, 32'h14, 4'hF, 32'h0, 32'h0, 16'h0};
        tbl[6]  = '{1'b0, 32'h18, 4'hF, 32'h0, 32'h0, 16'h0};
        tbl[7]  = '{1'b0, 32'h1C, 4'hF, 32'h0, 32'h0, 16'h0};
        tbl[8]  = '{1'b1, 32'h00, 4'h1, 32'h0000A5A5, 32'h0, 16'h00A5};
        tbl[9]  = '{1'b1, 32'h0C, 4'hF, 32'h00000F00, 32'h0, 16'h0FA5};
        tbl[10] = '{1'b1, 32'h10, 4'hF, 32'h00000005, 32'h0, 16'h0FA0};
        tbl[11] = '{1'b0, 32'h00, 4'hF, 32'h0, 32'h00000FA0, 16'h0FA0};
        tbl[12] = '{1'b0, 32'h0C, 4'hF, 32'h0, 32'h0, 16'h0FA0};
        tbl[13] = '{1'b0, 32'h10, 4'hF, 32'h0, 32'h0, 16'h0FA0};
        tbl[14] = '{1'b1, 32'h40, 4'hF, 32'hFFFFFFFF, 32'h0, 16'h0FA0};
        tbl[15] = '{1'b0, 32'h40, 4'hF, 32'h0, 32'h0, 16'h0FA0};
        tbl[16] = '{1'b1, 32'h00, 4'h2, 32'h12345678, 32'h0, 16'h56A0};
        tbl[17] = '{1'b0, 32'h10000000, 4'hF, 32'h0, 32'h000056A0, 16'h56A0};
        tbl[18] = '{1'b1, 32'h14, 4'hF, 32'h000001FF, 32'h0, 16'h56A0};
        tbl[19] = '{1'b0, 32'h14, 4'hF, 32'h0, 32'h000000FF, 16'h56A0};
        tbl[20] = '{1'b1, 32'h14, 4'hF, 32'h00000001, 32'h0, 16'h56A0};
        tbl[21] = '{1'b0, 32'h14, 4'hF, 32'h0, 32'h00000001, 16'h56A0};
        tbl[22] = '{1'b1, 32'h18, 4'hF, 32'h00000000, 32'h0, 16'h56A0};
        tbl[23] = '{1'b0, 32'h1C, 4'hF, 32'h0, 32'h0, 16'h56A0};

        m_reset();
        rst_ni = 1'b0; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
        gp_i = '0;
        #1;
        chk("reset_gp_o",   {16'h0, gp_o},   32'h0);
        chk("reset_irq",    {31'h0, irq},    32'h0);
        chk("reset_rvalid", {31'h0, rvalid}, 32'h0);
        tick(); tick();
        rst_ni = 1'b1;

        // Register map vectors, one request per cycle back to back.
        for (int i = 0; i < 24; i++) begin
            bus_op(tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wdata);
            chk($sformatf("vec%0d_rvalid", i), {31'h0, rvalid}, 32'h1);
            chk($sformatf("vec%0d_rdata", i), rdata, tbl[i].exp_rdata);
            chk($sformatf("vec%0d_gp_o", i), {16'h0, gp_o}, {16'h0, tbl[i].exp_gpo});
        end

        // Rising edge on input 0 with RISE_EN[0]=1: dbnc and irq timing.
        gp_i = 8'h01;
        for (int e = 1; e <= c_LAT + 3; e++) begin
            bus_op(1'b0, 32'h08, 4'hF, 32'h0);
            chk($sformatf("rise_in_dbnc_e%0d", e), rdata, (e > c_LAT) ? 32'h1 : 32'h0);
            chk($sformatf("rise_irq_e%0d", e), {31'h0, irq},
                (e >= c_LAT + 2) ? 32'h1 : 32'h0);
        end
        bus_read("rise_status", 32'h1C, 32'h1);

        // Falling edge with FALL_EN=0 adds nothing; status stays sticky.
        gp_i = 8'h00;
        for (int e = 0; e < c_LAT + 3; e++) tick();
        bus_read("fall_status", 32'h1C, 32'h1);
        chk("fall_irq", {31'h0, irq}, 32'h1);

        // W1C clears status at the write edge; irq follows one edge later.
        bus_op(1'b1, 32'h1C, 4'h1, 32'h1);
        chk("w1c_irq_hold", {31'h0, irq}, 32'h1);
        bus_read("w1c_status", 32'h1C, 32'h0);
        chk("w1c_irq_drop", {31'h0, irq}, 32'h0);

        // Hardware set collides with a W1C of the same bit: set wins.
        gp_i = 8'h01;
        for (int e = 1; e <= c_LAT; e++) tick();
        bus_op(1'b1, 32'h1C, 4'hF, 32'h1);
        chk("coll_irq_pre", {31'h0, irq}, 32'h0);
        bus_read("coll_status", 32'h1C, 32'h1);
        chk("coll_irq", {31'h0, irq}, 32'h1);

        gp_i = 8'h00;
        for (int e = 0; e < c_LAT + 3; e++) tick();
        // W1C with all byte enables off leaves status alone.
        bus_op(1'b1, 32'h1C, 4'h0, 32'hFF);
        bus_read("w1c_be0_status", 32'h1C, 32'h1);
        bus_op(1'b1, 32'h1C, 4'hF, 32'hFF);
        bus_read("w1c_all_status", 32'h1C, 32'h0);

`ifdef GPIO_CTRL_DEBOUNCE_EN
        // A pulse one cycle shorter than the debounce window is rejected.
        gp_i = 8'h01;
        for (int e = 0; e < DBNC - 1; e++) tick();
        gp_i = 8'h00;
        for (int e = 0; e < c_LAT + 4; e++) tick();
        bus_read("glitch_in_dbnc", 32'h08, 32'h0);
        bus_read("glitch_status", 32'h1C, 32'h0);
`endif

        // Randomized traffic against the reference model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int sel;
            if (cyc == 1500) begin
                req = 1'b0;
                rst_ni = 1'b0;
                #1;
                chk("async_rst_gp_o",   {16'h0, gp_o},   32'h0);
                chk("async_rst_irq",    {31'h0, irq},    32'h0);
                chk("async_rst_rvalid", {31'h0, rvalid}, 32'h0);
                chk("async_rst_rdata",  rdata,           32'h0);
                tick();
                rst_ni = 1'b1;
            end
            if ($urandom_range(0, 5) == 0) gp_i[$urandom_range(0, GPI - 1)] ^= 1'b1;
            req   = ($urandom_range(0, 1) == 1);
            we    = ($urandom_range(0, 2) == 0);
            be    = 4'($urandom);
            wdata = $urandom;
            sel   = $urandom_range(0, 10);
            if (sel < 8)       addr = 32'(sel * 4);
            else if (sel == 8) addr = 32'h40;
            else if (sel == 9) addr = {20'($urandom), 12'h0} | 32'(4 * $urandom_range(0, 7));
            else               addr = $urandom & 32'hFFFF_FFFC;
            tick();
            check_all($sformatf("rand%0d", cyc));
        end
        req = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
